// File: rtl/div_rr_sequencer.sv
// Two-requester round-robin front end sharing one iterative restoring divider.
// Each operation takes WIDTH enabled cycles. A zero divisor goes straight to the response.
module div_rr_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div0,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
    logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_div0_q, rsp_div0_d;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // Both requesting: serve whoever was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept       = (state_q == StIdle) && ena && (req0_valid || req1_valid);
    assign req0_ready   = accept && !grant;
    assign req1_ready   = accept && grant;
    assign sel_dividend = grant ? req1_dividend : req0_dividend;
    assign sel_divisor  = grant ? req1_divisor  : req0_divisor;

    // The difference is below the divisor whenever it is kept, so WIDTH bits hold it exactly.
    assign trial    = {r_q, q_q[WIDTH-1]};
    assign trial_ge = trial >= {1'b0, d_q};
    assign r_step   = trial_ge ? (trial[WIDTH-1:0] - d_q) : trial[WIDTH-1:0];
    assign q_step   = {q_q[WIDTH-2:0], trial_ge};

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        id_d            = id_q;
        r_d             = r_q;
        q_d             = q_q;
        d_d             = d_q;
        count_d         = count_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_id_d        = rsp_id_q;
        rsp_div0_d      = rsp_div0_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = grant;
                    id_d         = grant;
                    d_d          = sel_divisor;
                    if (sel_divisor == '0) begin
                        state_d         = StDone;
                        rsp_quotient_d  = '1;
                        rsp_remainder_d = '1;
                        rsp_id_d        = grant;
                        rsp_div0_d      = 1'b1;
                    end else begin
                        state_d = StCalc;
                        r_d     = '0;
                        q_d     = sel_dividend;
                        count_d = CW'(WIDTH - 1);
                    end
                end
            end
            StCalc: begin
                if (ena) begin
                    r_d = r_step;
                    q_d = q_step;
                    if (count_q == '0) begin
                        state_d         = StDone;
                        rsp_quotient_d  = q_step;
                        rsp_remainder_d = r_step;
                        rsp_id_d        = id_q;
                        rsp_div0_d      = 1'b0;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            last_grant_q    <= 1'b1;
            id_q            <= 1'b0;
            r_q             <= '0;
            q_q             <= '0;
            d_q             <= '0;
            count_q         <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_id_q        <= 1'b0;
            rsp_div0_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            id_q            <= id_d;
            r_q             <= r_d;
            q_q             <= q_d;
            d_q             <= d_d;
            count_q         <= count_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_id_q        <= rsp_id_d;
            rsp_div0_q      <= rsp_div0_d;
        end
    end

    assign rsp_valid     = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_div0      = rsp_div0_q;

endmodule

// File: tb/tb_div_rr_sequencer.sv
// Bench for div_rr_sequencer: arithmetic reference model checked every cycle,
// directed scenarios with literal results, then randomized traffic.
module tb_div_rr_sequencer;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n, ena;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_div0, busy;
    logic [WIDTH-1:0] rsp_quotient, rsp_remainder;

    div_rr_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_dividend(req0_dividend),
        .req0_divisor (req0_divisor),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_dividend(req1_dividend),
        .req1_divisor (req1_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_div0     (rsp_div0),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 holding a result.
    int               m_phase;
    int               m_left;
    logic             m_last, m_id;
    logic [WIDTH-1:0] m_pq, m_pr, m_rq, m_rr;
    logic             m_rid, m_rdiv0;

    function automatic logic model_grant();
        if (req0_valid && req1_valid) return ~m_last;
        return req1_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_last <= 1'b1; m_id <= 1'b0;
            m_pq <= '0; m_pr <= '0; m_rq <= '0; m_rr <= '0; m_rid <= 1'b0; m_rdiv0 <= 1'b0;
        end else begin
            case (m_phase)
                0: if (ena && (req0_valid || req1_valid)) begin
                    m_last <= model_grant();
                    m_id   <= model_grant();
                    if ((model_grant() ? req1_divisor : req0_divisor) == 0) begin
                        m_phase <= 2;
                        m_rq    <= '1;
                        m_rr    <= '1;
                        m_rdiv0 <= 1'b1;
                        m_rid   <= model_grant();
                    end else begin
                        m_phase <= 1;
                        m_left  <= WIDTH;
                        m_pq    <= model_grant() ? req1_dividend / req1_divisor
                                                 : req0_dividend / req0_divisor;
                        m_pr    <= model_grant() ? req1_dividend % req1_divisor
                                                 : req0_dividend % req0_divisor;
                    end
                end
                1: if (ena) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_rq    <= m_pq;
                        m_rr    <= m_pr;
                        m_rdiv0 <= 1'b0;
                        m_rid   <= m_id;
                    end
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    int   cyc = 0;
    int   acc_cyc = 0, rise_cyc = 0;
    logic prev_rv = 1'b0;
    int   acc_log[$];
    logic [17:0] rsp_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the model, plus logging of accepts and responses.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("req0_ready", 32'(req0_ready),
                32'(m_phase == 0 && ena && (req0_valid || req1_valid) && model_grant() == 1'b0));
            chk("req1_ready", 32'(req1_ready),
                32'(m_phase == 0 && ena && (req0_valid || req1_valid) && model_grant() == 1'b1));
            if (m_phase != 1) begin
                chk("rsp_data", {13'd0, rsp_div0, rsp_id, rsp_quotient, rsp_remainder},
                    {13'd0, m_rdiv0, m_rid, m_rq, m_rr});
            end
            if (req0_valid && req0_ready) begin acc_log.push_back(0); acc_cyc = cyc; end
            if (req1_valid && req1_ready) begin acc_log.push_back(1); acc_cyc = cyc; end
            if (rsp_valid && !prev_rv) rise_cyc = cyc;
            if (rsp_valid && rsp_ready)
                rsp_log.push_back({rsp_div0, rsp_id, rsp_quotient, rsp_remainder});
        end
        prev_rv = rsp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, dropping any valid that was accepted on that edge.
    task automatic step();
        logic a0, a1;
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        tick();
        if (a0) req0_valid = 1'b0;
        if (a1) req1_valid = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while (rsp_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(rsp_log.size() >= n), 32'd1);
    endtask

    task automatic wait_accept(input int budget, input string name);
        int n0 = acc_log.size();
        int k  = 0;
        while (acc_log.size() == n0 && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(acc_log.size() > n0), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("reset_outputs", {25'd0, busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_div0,
                              rsp_quotient != 0 || rsp_remainder != 0}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0_dividend = a; req0_divisor = b; req0_valid = 1'b1;
    endtask

    task automatic set1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1_dividend = a; req1_divisor = b; req1_valid = 1'b1;
    endtask

    int base;
    int r0_count;

    initial begin
        rst_n = 1'b0; ena = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dividend = '0; req0_divisor = '0; req1_dividend = '0; req1_divisor = '0;
        tick();
        do_reset();

        // req0 100/7 alone
        rsp_ready = 1'b1;
        set0(8'd100, 8'd7);
        r0_count = 0;
        while (rsp_log.size() < 1 && r0_count < 40) begin
            step();
            r0_count++;
        end
        chk("t1_done", 32'(rsp_log.size()), 32'd1);
        chk("t1_result", 32'(rsp_log[0]), {14'd0, 1'b0, 1'b0, 8'd14, 8'd2});
        chk("t1_latency", 32'(rise_cyc - acc_cyc - 1), 32'd8);
        chk("t1_accepts", 32'(acc_log.size()), 32'd1);

        // req1 55/0
        set1(8'd55, 8'd0);
        run_until(2, 20, "t2_done");
        chk("t2_result", 32'(rsp_log[1]), {14'd0, 1'b1, 1'b1, 8'hFF, 8'hFF});
        chk("t2_latency", 32'(rise_cyc - acc_cyc), 32'd1);

        // Both valid from reset, then both again
        do_reset();
        base = rsp_log.size();
        set0(8'd200, 8'd3);
        set1(8'd9, 8'd4);
        run_until(base + 2, 60, "t3_done");
        chk("t3_first", 32'(rsp_log[base]), {14'd0, 1'b0, 1'b0, 8'd66, 8'd2});
        chk("t3_second", 32'(rsp_log[base + 1]), {14'd0, 1'b0, 1'b1, 8'd2, 8'd1});
        set0(8'd20, 8'd6);
        set1(8'd30, 8'd7);
        run_until(base + 4, 60, "t3b_done");
        chk("t3b_order", 32'(acc_log[acc_log.size() - 2]), 32'd0);
        chk("t3b_first", 32'(rsp_log[base + 2]), {14'd0, 1'b0, 1'b0, 8'd3, 8'd2});
        chk("t3b_second", 32'(rsp_log[base + 3]), {14'd0, 1'b0, 1'b1, 8'd4, 8'd2});

        // Back-pressure in DONE with 255/1
        rsp_ready = 1'b0;
        base = rsp_log.size();
        set0(8'd255, 8'd1);
        r0_count = 0;
        while (!rsp_valid && r0_count < 40) begin
            step();
            r0_count++;
        end
        chk("t4_valid", 32'(rsp_valid), 32'd1);
        set1(8'd5, 8'd5);
        repeat (5) begin
            #1;
            chk("t4_hold", {14'd0, rsp_valid, req0_ready, req1_ready, rsp_quotient, rsp_remainder},
                {14'd0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0});
            tick();
        end
        rsp_ready = 1'b1;
        set0(8'd0, 8'd5);
        run_until(base + 3, 80, "t4_done");
        chk("t4_r0", 32'(rsp_log[base]), {14'd0, 1'b0, 1'b0, 8'd255, 8'd0});
        chk("t4_r1", 32'(rsp_log[base + 1]), {14'd0, 1'b0, 1'b1, 8'd1, 8'd0});
        chk("t4_r2", 32'(rsp_log[base + 2]), {14'd0, 1'b0, 1'b0, 8'd0, 8'd0});

        // ena low for 3 cycles mid-computation on 77/10
        base = rsp_log.size();
        set0(8'd77, 8'd10);
        wait_accept(20, "t5_accept");
        repeat (3) tick();
        ena = 1'b0;
        repeat (3) tick();
        ena = 1'b1;
        run_until(base + 1, 40, "t5_done");
        chk("t5_result", 32'(rsp_log[base]), {14'd0, 1'b0, 1'b0, 8'd7, 8'd7});
        chk("t5_latency", 32'(rise_cyc - acc_cyc - 1), 32'd11);

        // Reset mid-computation, then a fresh 9/2 with req0 winning
        set0(8'd77, 8'd10);
        wait_accept(20, "t6_accept");
        repeat (4) tick();
        do_reset();
        base = rsp_log.size();
        set0(8'd9, 8'd2);
        set1(8'd3, 8'd3);
        run_until(base + 2, 60, "t6_done");
        chk("t6_first", 32'(rsp_log[base]), {14'd0, 1'b0, 1'b0, 8'd4, 8'd1});
        chk("t6_second", 32'(rsp_log[base + 1]), {14'd0, 1'b0, 1'b1, 8'd1, 8'd0});

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            req0_valid    = ($urandom_range(9, 0) < 6);
            req1_valid    = ($urandom_range(9, 0) < 6);
            req0_dividend = 8'($urandom);
            req1_dividend = 8'($urandom);
            req0_divisor  = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom);
            req1_divisor  = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom_range(15, 1));
            ena           = ($urandom_range(9, 0) != 0);
            rsp_ready     = ($urandom_range(9, 0) < 7);
            tick();
        end
        ena = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_rr_sequencer.md
Name: div_rr_sequencer

Overview:
- Round-robin arbiter plus multi-cycle restoring shift-subtract divider, shared between two requesters.
- Replaces per-requester combinational dividers with one WIDTH-cycle iterative datapath.
- Valid/ready handshakes on both request ports and the response port.
- Divide-by-zero convention is unchanged: quotient and remainder are all ones.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (minimum 2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes the block
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_dividend  input  WIDTH  requester 0 dividend
req0_divisor  input  WIDTH  requester 0 divisor
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_dividend  input  WIDTH  requester 1 dividend
req1_divisor  input  WIDTH  requester 1 divisor
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester index of the result
rsp_quotient  output  WIDTH  quotient
rsp_remainder  output  WIDTH  remainder
rsp_div0  output  1  result came from a zero divisor
busy  output  1  state is not IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0, internal registers 0, last_grant=1 so req0 wins first.
- States: IDLE, CALC, DONE.
- IDLE grant (combinational):
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && ena && grant==N. At most one ready is high at a time.
  - A ready never asserts outside IDLE.
- Accept edge (valid && ready):
  - Capture dividend, divisor and id. Set last_grant=id.
  - Divisor==0: next state DONE, quotient=all ones, remainder=all ones, div0=1.
  - Otherwise: next state CALC, R=0 (WIDTH+1 bits), Q=dividend, count=WIDTH-1.
- CALC: each cycle with ena=1 performs one iteration.
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If T >= D: R=T-D and shift 1 into Q LSB. Else: R=T and shift 0 in.
  - When the iteration runs at count==0, the next state is DONE. Otherwise count decrements.
  - All arithmetic is unsigned, WIDTH+1-bit compare and subtract, no overflow possible.
- Latency:
  - rsp_valid rises exactly WIDTH enabled cycles after the accept edge.
  - For a zero divisor it rises 1 cycle after the accept edge.
- DONE:
  - rsp_valid=1. rsp_quotient, rsp_remainder, rsp_id and rsp_div0 stay stable until rsp_ready=1.
  - On the rsp_valid && rsp_ready edge: state IDLE, rsp_valid=0 at that same edge.
  - No new request is accepted in that cycle. The minimum accept-to-accept spacing is WIDTH+2 cycles.
- rsp data outputs hold their last value in IDLE. Only rsp_valid qualifies them.
- ena=0:
  - No state, counter or datapath change.
  - No ready is asserted.
  - In DONE, rsp_valid stays high and a handshake still completes (rsp_ready is honoured regardless of ena).
- Request inputs are sampled only on the accept edge. Later changes while busy have no effect.
- A requester that holds valid while the other is granted is served next; there is no starvation.
- Reset mid-CALC or mid-DONE aborts the operation. The result is lost and the block returns to the reset values above.

Test Plan:
- Reset, req0 100/7 only, rsp_ready=1 -> req0_ready high 1 cycle; rsp_valid 8 cycles after accept with q=14, r=2, id=0, div0=0.
- req1 55/0 -> rsp_valid 1 cycle after accept with q=0xFF, r=0xFF, div0=1, id=1.
- Both valid from reset (req0 200/3, req1 9/4), rsp_ready=1 -> req0 served first (66 r2), then req1 (2 r1). Then both again -> req0 granted since last_grant=1.
- rsp_ready low for 5 cycles in DONE with 255/1 -> rsp_valid and q=255, r=0 held stable, no ready asserted; then 0/5 -> q=0, r=0.
- ena low 3 cycles mid-CALC on 77/10 -> rsp_valid delayed to 11 cycles after accept, q=7, r=7.
- rst_n low for 1 cycle mid-CALC -> all outputs 0 immediately; a fresh 9/2 afterwards gives q=4, r=1 with req0 priority.
